// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter. It sends a start bit, 5-8 data bits LSB
// first, an optional parity bit and 1 or 2 stop bits. Bit timing comes from an
// OVERSAMPLE-times-baud tick enable, so each bit lasts OVERSAMPLE ticks.
module uart_tx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_tick,
  input  logic       i_tx_start,
  input  logic [7:0] i_data,
  input  logic [1:0] i_num_bit_data,
  input  logic       i_stop_bit,
  input  logic       i_parity_en,
  input  logic       i_parity_type,
  output logic       o_tx_serial,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic [2:0]      last_idx;
  logic            two_stop;
  logic            parity_en;
  logic            parity_bit;

  logic            bit_end;
  logic [7:0]      width_mask;
  logic            parity_next;

  // A bit period ends on the tick that wraps the tick counter.
  assign bit_end = tx_tick && (tick_cnt == TICK_LAST);

  // Parity of only the bits that will actually be sent, computed at acceptance.
  always_comb begin
    width_mask  = 8'hFF >> (2'd3 - i_num_bit_data);
    parity_next = (^(i_data & width_mask)) ^ i_parity_type;
  end

  // Frame sequencer: latches the request, walks the frame bit by bit, drives registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      last_idx    <= '0;
      two_stop    <= 1'b0;
      parity_en   <= 1'b0;
      parity_bit  <= 1'b0;
      o_tx_serial <= 1'b1;
      o_tx_busy   <= 1'b0;
      o_tx_done   <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;

      // Ticks only count while a frame is in flight; IDLE holds the counter at 0
      // so a tick coinciding with acceptance does not shorten the start bit further.
      if (tx_tick && (state != IDLE)) begin
        tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
      end

      case (state)
        IDLE: begin
          o_tx_serial <= 1'b1;
          o_tx_busy   <= 1'b0;
          if (i_tx_start) begin
            shift       <= i_data;
            last_idx    <= 3'd4 + {1'b0, i_num_bit_data};
            two_stop    <= i_stop_bit;
            parity_en   <= i_parity_en;
            parity_bit  <= parity_next;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            o_tx_serial <= 1'b0;
            o_tx_busy   <= 1'b1;
            state       <= START;
          end
        end

        START: begin
          if (bit_end) begin
            o_tx_serial <= shift[0];
            state       <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_cnt == last_idx) begin
              bit_cnt <= '0;
              if (parity_en) begin
                o_tx_serial <= parity_bit;
                state       <= PARITY;
              end else begin
                o_tx_serial <= 1'b1;
                state       <= STOP;
              end
            end else begin
              bit_cnt     <= bit_cnt + 3'd1;
              shift       <= {1'b0, shift[7:1]};
              o_tx_serial <= shift[1];
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            o_tx_serial <= 1'b1;
            bit_cnt     <= '0;
            state       <= STOP;
          end
        end

        STOP: begin
          if (bit_end) begin
            // bit_cnt marks that the first of two stop bits has been sent.
            if (two_stop && (bit_cnt == 3'd0)) begin
              bit_cnt <= 3'd1;
            end else begin
              bit_cnt     <= '0;
              o_tx_serial <= 1'b1;
              o_tx_busy   <= 1'b0;
              o_tx_done   <= 1'b1;
              state       <= IDLE;
            end
          end
        end

        default: begin
          o_tx_serial <= 1'b1;
          o_tx_busy   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized frames against a bit-level reference
// model of the serial line (expected level for every bit period).
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_tick = 1'b0;
  logic       i_tx_start = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic [1:0] i_num_bit_data = 2'b11;
  logic       i_stop_bit = 1'b0;
  logic       i_parity_en = 1'b0;
  logic       i_parity_type = 1'b0;
  logic       o_tx_serial;
  logic       o_tx_busy;
  logic       o_tx_done;

  int errors = 0;
  int checks = 0;

  // Reference model state for the frame in flight
  logic       exp_bits[$];
  logic [7:0] exp_data;
  int         exp_width;
  int         frames_sent = 0;

  uart_tx #(.OVERSAMPLE(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_tick        (tx_tick),
    .i_tx_start     (i_tx_start),
    .i_data         (i_data),
    .i_num_bit_data (i_num_bit_data),
    .i_stop_bit     (i_stop_bit),
    .i_parity_en    (i_parity_en),
    .i_parity_type  (i_parity_type),
    .o_tx_serial    (o_tx_serial),
    .o_tx_busy      (o_tx_busy),
    .o_tx_done      (o_tx_done)
  );

  always #5 clk = ~clk;

  // Free-running single-cycle tick every third clock, changed on the falling edge
  initial begin
    int div = 0;
    forever begin
      @(negedge clk);
      tx_tick = (div == 0);
      div = (div + 1) % 3;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level per bit period, straight from the frame format
  function automatic void build_model(input logic [7:0] d, input logic [1:0] nb,
                                      input logic sb, input logic pen, input logic pt);
    logic p;
    exp_bits.delete();
    exp_width = 5 + int'(nb);
    exp_data  = 8'h00;
    p = pt;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < exp_width; i++) begin
      exp_bits.push_back(d[i]);
      exp_data[i] = d[i];
      p = p ^ d[i];
    end
    if (pen) exp_bits.push_back(p);
    exp_bits.push_back(1'b1);
    if (sb) exp_bits.push_back(1'b1);
  endfunction

  // Call at a non-edge time; returns 1 ns after the accepting edge
  task automatic start_frame(input logic [7:0] d, input logic [1:0] nb,
                             input logic sb, input logic pen, input logic pt);
    i_data = d; i_num_bit_data = nb; i_stop_bit = sb;
    i_parity_en = pen; i_parity_type = pt;
    i_tx_start = 1'b1;
    build_model(d, nb, sb, pen, pt);
    @(posedge clk); #1;
    i_tx_start = 1'b0;
    frames_sent++;
    $display("frame %0d: data=%02h bits=%0d parity_en=%0d odd=%0d stops=%0d",
             frames_sent, d, exp_width, pen, pt, 1 + int'(sb));
    check("accept_busy", o_tx_busy, 1);
    check("accept_line", o_tx_serial, 0);
    // Scramble inputs: the frame in progress must not notice
    i_data = 8'($urandom); i_num_bit_data = 2'($urandom);
    i_stop_bit = 1'($urandom); i_parity_en = 1'($urandom); i_parity_type = 1'($urandom);
  endtask

  // Follows the frame tick by tick; returns in the o_tx_done cycle (or after reset)
  task automatic run_frame(input int busy_start_at, input int rst_at);
    int k = 0;
    int total = 16 * exp_bits.size();
    logic [7:0] got = 8'h00;
    bit finished = 1'b0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(posedge clk); #1;
      if (i_tx_start) i_tx_start = 1'b0;
      if (tx_tick) k++;
      if (o_tx_done) begin
        check("done_tick_count", k, total);
        check("done_busy", o_tx_busy, 0);
        check("done_line", o_tx_serial, 1);
        check("rx_data", got, exp_data);
        finished = 1'b1;
      end else if (tx_tick) begin
        if (k >= total) begin
          check("frame_overrun", k, total - 1);
          finished = 1'b1;
        end else begin
          check($sformatf("line_k%0d", k), o_tx_serial, exp_bits[k / 16]);
          check("busy_in_frame", o_tx_busy, 1);
          if ((k % 16) == 8 && (k / 16) >= 1 && (k / 16) <= exp_width)
            got[(k / 16) - 1] = o_tx_serial;
          if (k == busy_start_at) begin
            i_data = 8'h55; i_tx_start = 1'b1;
          end
          if (k == rst_at) begin
            rst_n = 1'b0;
            #2;
            check("async_rst_line", o_tx_serial, 1);
            check("async_rst_busy", o_tx_busy, 0);
            check("async_rst_done", o_tx_done, 0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("post_rst_idle_busy", o_tx_busy, 0);
            return;
          end
        end
      end
    end
    if (!finished) check("frame_timeout", o_tx_done, 1);
  endtask

  // One idle cycle after a frame: done must have been a single pulse
  task automatic idle_check();
    @(posedge clk); #1;
    check("done_one_cycle", o_tx_done, 0);
    check("idle_busy", o_tx_busy, 0);
    check("idle_line", o_tx_serial, 1);
  endtask

  task automatic idle_wait();
    repeat ($urandom_range(0, 5)) @(posedge clk);
    #1;
  endtask

  initial begin
    int done_pulses;
    int busy_cycles;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_line", o_tx_serial, 1);
    check("rst_busy", o_tx_busy, 0);
    check("rst_done", o_tx_done, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 8N1 0xA5
    start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0); run_frame(-1, -1); idle_check();
    // 8E1 / 8O1 0x03
    idle_wait(); start_frame(8'h03, 2'b11, 1'b0, 1'b1, 1'b0); run_frame(-1, -1); idle_check();
    idle_wait(); start_frame(8'h03, 2'b11, 1'b0, 1'b1, 1'b1); run_frame(-1, -1); idle_check();
    // 5N1 0xFF: only five data bits
    idle_wait(); start_frame(8'hFF, 2'b00, 1'b0, 1'b0, 1'b0); run_frame(-1, -1); idle_check();
    // 8N2 0x00
    idle_wait(); start_frame(8'h00, 2'b11, 1'b1, 1'b0, 1'b0); run_frame(-1, -1); idle_check();

    // Randomized frames, some chained back-to-back in the done cycle
    idle_wait();
    start_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    for (int n = 0; n < 8; n++) begin
      run_frame(-1, -1);
      if ($urandom_range(0, 1) == 1) begin
        idle_check();
        idle_wait();
      end
      start_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    run_frame(-1, -1); idle_check();

    // Start while busy is ignored; then a back-to-back start in the done cycle
    idle_wait();
    start_frame(8'hC3, 2'b11, 1'b0, 1'b1, 1'b0);
    run_frame(40, -1);
    start_frame(8'h96, 2'b10, 1'b1, 1'b0, 1'b0);
    run_frame(-1, -1);
    done_pulses = 0; busy_cycles = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (o_tx_done) done_pulses++;
      if (o_tx_busy) busy_cycles++;
    end
    check("no_extra_done", done_pulses, 0);
    check("no_extra_frame", busy_cycles, 0);

    // Reset mid-frame during DATA, then a clean 0x3C frame
    start_frame(8'hE7, 2'b11, 1'b0, 1'b0, 1'b0);
    run_frame(-1, 40);
    idle_wait();
    start_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0); run_frame(-1, -1); idle_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the stage upstream of `uart_rx` on the serial link. It accepts a parallel byte with a one-cycle start strobe and shifts out a framed character on `o_tx_serial`: start bit, 5–8 data bits LSB first, optional parity bit, then 1 or 2 stop bits. Bit timing comes from the shared 16x oversampling `tx_tick` enable, the same tick source `uart_rx` uses. Frame configuration uses the same encodings as `uart_rx`, so a TX/RX pair with identical settings interoperate.

## Interface
- `OVERSAMPLE`, 16: `tx_tick` pulses per bit period.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_tick` in 1: one-cycle enable pulse at OVERSAMPLE × baud rate.
- `i_tx_start` in 1: one-cycle request to send `i_data`.
- `i_data` in 8: character to send.
- `i_num_bit_data` in 2: data width. 00=5, 01=6, 10=7, 11=8 bits.
- `i_stop_bit` in 1: 0 = one stop bit, 1 = two stop bits.
- `i_parity_en` in 1: 1 = insert a parity bit.
- `i_parity_type` in 1: 0 = even, 1 = odd.
- `o_tx_serial` out 1: serial line; idles high.
- `o_tx_busy` out 1: high from the accepted start until the frame completes.
- `o_tx_done` out 1: one-cycle pulse when the last stop bit ends.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `o_tx_serial`=1, `o_tx_busy`=0.
  - When `i_tx_start` is high, the block latches `i_data`, width, stop count, parity enable and parity type into internal registers, clears the tick and bit counters, and moves to START.
- **Config latching:** input changes after acceptance do not affect the frame in progress.
- **START:** line driven 0 for OVERSAMPLE ticks, then DATA.
- **DATA**
  - Bit i of the latched data is driven for OVERSAMPLE ticks, i = 0 .. width-1.
  - Latched bits at or above the width are never sent.
  - After the last bit: PARITY if parity is enabled, else STOP.
- **PARITY**
  - Parity bit p = XOR of the sent data bits, inverted when odd parity is selected.
  - p is driven for OVERSAMPLE ticks, then STOP.
- **STOP**
  - Line driven 1 for OVERSAMPLE ticks (one stop bit) or 2×OVERSAMPLE ticks (two stop bits), then IDLE.
- **Tick counter:** 4 bits for OVERSAMPLE=16. It advances only on `tx_tick` and wraps to 0 at OVERSAMPLE-1, which ends the bit.
- **Bit counter:** 3 bits, counts data bits sent.
- **Start while busy:** `i_tx_start` while `o_tx_busy`=1 is ignored. There is no queue and no error flag.
- **Reset:** `rst_n` low at any time, including mid-frame, forces IDLE and the output values below immediately. Any partial frame is abandoned.
- **Reset values:** `o_tx_serial`=1, `o_tx_busy`=0, `o_tx_done`=0, all counters 0.

## Timing
- **Outputs:** all registered.
- **Acceptance:** `i_tx_start` sampled high in IDLE on edge N gives `o_tx_busy`=1 and `o_tx_serial`=0 from edge N+1.
- **Short start bit:** the start bit ends on the OVERSAMPLE-th `tx_tick` after acceptance. It can therefore be up to one tick period short. This is acceptable because the receiver samples at mid-bit.
- **Bit boundaries:** every later bit boundary coincides exactly with a `tx_tick` cycle.
- **Frame length** in ticks = OVERSAMPLE × (1 + width + parity_en + 1 + stop_bit). Example: 8N1 = 160 ticks; 5-bit, parity, 2 stop = 144 ticks.
- **Frame end:** on the edge that consumes the final stop tick, state returns to IDLE. On that same edge `o_tx_busy` goes 0 and `o_tx_done` goes 1 for exactly one cycle.
- **Back-to-back frames:** `i_tx_start` asserted in the `o_tx_done` cycle is accepted. The next start bit follows with no extra idle time.
- **Tick and start in the same cycle (IDLE):** the tick is not counted toward the start bit.
- **Held `tx_tick`:** not permitted. Behaviour is defined only for single-cycle pulses.

## Test plan
- **8N1, `i_data`=0xA5:** line shows 0, 1,0,1,0,0,1,0,1, then 1, each bit 16 ticks. `o_tx_done` pulses once after 160 ticks. A looped-back `uart_rx` returns 0xA5.
- **8E1, 0x03:** parity bit = 0. **8O1, 0x03:** parity bit = 1. In both cases the looped-back `uart_rx` reports `o_parity_err`=0.
- **5-bit, no parity, `i_data`=0xFF:** only five 1 data bits are sent, frame is 112 ticks, and `uart_rx` returns 0x1F.
- **8N2, 0x00:** stop level held for 32 ticks; `o_tx_done` at tick 176.
- **Start while busy:** pulse `i_tx_start` with 0x55 mid-frame. The frame in progress is unchanged, no second frame is sent, and exactly one `o_tx_done` pulse occurs. Then pulse start in the `o_tx_done` cycle; the next start bit begins on the following edge.
- **Reset mid-frame:** assert `rst_n`=0 during DATA. `o_tx_serial` goes 1 and busy and done go 0 without waiting for a clock edge. After release, a new 0x3C frame transmits correctly.
